// File: rtl/float_copro_seq_pkg.sv
// Float format, opcodes, FSM states and the combinational add/sub/mul helpers.
// Zeros and subnormals flush to zero; overflow saturates to the largest finite value.
package float_copro_seq_pkg;
    localparam int N_exposant = 8;
    localparam int N_mantisse = 23;
    localparam int BIAS       = 2**(N_exposant-1) - 1;
    localparam int MW         = N_mantisse + 1;
    localparam int GW         = N_mantisse + 4;

    localparam logic [N_exposant-1:0] EXP_SAT = N_exposant'(2**N_exposant - 2);

    typedef struct packed {
        logic                  sign;
        logic [N_exposant-1:0] exposant;
        logic [N_mantisse-1:0] mantisse;
    } float;

    typedef enum logic [1:0] {FOP_ADD, FOP_SUB, FOP_MUL, FOP_DIV} fop_e;
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;

    function automatic float pack_result(logic sign, int e, logic [N_mantisse-1:0] m);
        float y;
        y = '0;
        if (e > int'(EXP_SAT)) begin
            y.sign     = sign;
            y.exposant = EXP_SAT;
            y.mantisse = '1;
        end else if (e > 0) begin
            y.sign     = sign;
            y.exposant = e[N_exposant-1:0];
            y.mantisse = m;
        end
        return y;
    endfunction

    function automatic float float_mul(float a, float b);
        logic [2*MW-1:0] p;
        int              e;
        if (a.exposant == '0 || b.exposant == '0)
            return '0;
        p = {{MW{1'b0}}, 1'b1, a.mantisse} * {{MW{1'b0}}, 1'b1, b.mantisse};
        e = int'(a.exposant) + int'(b.exposant) - BIAS;
        if (p[2*MW-1])
            return pack_result(a.sign ^ b.sign, e + 1, p[2*MW-2 -: N_mantisse]);
        return pack_result(a.sign ^ b.sign, e, p[2*MW-3 -: N_mantisse]);
    endfunction

    function automatic float float_add(float a, float b);
        float          big, sml;
        logic [GW-1:0] mb, ms;
        logic [GW:0]   s;
        int            d, e, lz;
        logic          found;
        if (a.exposant == '0 && b.exposant == '0) return '0;
        if (a.exposant == '0) return b;
        if (b.exposant == '0) return a;
        if ({a.exposant, a.mantisse} >= {b.exposant, b.mantisse}) begin
            big = a; sml = b;
        end else begin
            big = b; sml = a;
        end
        d  = int'(big.exposant) - int'(sml.exposant);
        mb = {1'b1, big.mantisse, 3'b000};
        ms = {1'b1, sml.mantisse, 3'b000};
        ms = (d >= GW) ? '0 : (ms >> d);
        e  = int'(big.exposant);
        if (big.sign == sml.sign) s = {1'b0, mb} + {1'b0, ms};
        else                      s = {1'b0, mb} - {1'b0, ms};
        if (s == '0) return '0;
        if (s[GW]) begin
            s = s >> 1;
            e = e + 1;
        end else begin
            lz = 0;
            found = 1'b0;
            for (int i = GW-1; i >= 0; i--) begin
                if (!found) begin
                    if (s[i]) found = 1'b1;
                    else      lz = lz + 1;
                end
            end
            s = s << lz;
            e = e - lz;
        end
        return pack_result(big.sign, e, s[GW-2 -: N_mantisse]);
    endfunction

    function automatic float float_sub(float a, float b);
        float nb;
        nb      = b;
        nb.sign = ~b.sign;
        return float_add(a, nb);
    endfunction
endpackage

// File: rtl/float_copro_seq_if.sv
// User-instruction side bus of the float coprocessor sequencer.
interface float_copro_seq_if;
    import float_copro_seq_pkg::*;
    logic        start;
    fop_e        opcode;
    float        op_a;
    float        op_b;
    logic        clr_status;
    logic        busy;
    logic        complete;
    float        result;
    logic [3:0]  status;
    logic [15:0] op_count;

    modport master (output start, opcode, op_a, op_b, clr_status,
                    input  busy, complete, result, status, op_count);
    modport slave  (input  start, opcode, op_a, op_b, clr_status,
                    output busy, complete, result, status, op_count);
endinterface

// File: rtl/float_copro_seq_alu.sv
// Combinational float datapath; FOP_DIV yields zero.
module float_copro_seq_alu
    import float_copro_seq_pkg::*;
(
    input  fop_e i_op,
    input  float i_a,
    input  float i_b,
    output float o_y
);
    always_comb begin
        o_y = '0;
        case (i_op)
            FOP_ADD: o_y = float_add(i_a, i_b);
            FOP_SUB: o_y = float_sub(i_a, i_b);
            FOP_MUL: o_y = float_mul(i_a, i_b);
            default: o_y = '0;
        endcase
    end
endmodule

// File: rtl/float_copro_seq.sv
// Sequencer: latches an op, waits ADD_LAT/MUL_LAT cycles on the combinational
// datapath, captures the result and keeps sticky status plus an op counter.
module float_copro_seq
    import float_copro_seq_pkg::*;
#(
    parameter int ADD_LAT = 2,
    parameter int MUL_LAT = 3,
    parameter int W       = 1 + N_exposant + N_mantisse
) (
    input logic               i_clk,
    input logic               i_reset_n,
    float_copro_seq_if.slave  bus
);
    localparam logic [3:0] ADD_CNT = 4'(ADD_LAT - 1);
    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

    state_e      r_state, w_state_nxt;
    logic [3:0]  r_cnt;
    fop_e        r_op;
    float        r_a, r_b;
    logic [W-1:0] r_result;
    logic [3:0]  r_status;
    logic [15:0] r_count;
    logic        r_ill;

    logic w_accept, w_illegal, w_capture, w_overrun, w_sat, w_unf;
    float w_y, w_nb;
    logic [3:0] w_set;

    float_copro_seq_alu u_alu (.i_op(r_op), .i_a(r_a), .i_b(r_b), .o_y(w_y));

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) r_state <= S_IDLE;
        else            r_state <= w_state_nxt;
    end

    // DONE accepts a new start exactly like IDLE so back-to-back ops lose no cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_illegal   = 1'b0;
        w_capture   = 1'b0;
        w_overrun   = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_state_nxt = S_IDLE;
                if (bus.start) begin
                    w_accept = 1'b1;
                    if (bus.opcode == FOP_DIV) begin
                        w_illegal   = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                w_overrun = bus.start;
                if (r_cnt == 4'd0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Underflow is suppressed when the exact add/sub result is zero (a == -b_eff).
    assign w_nb  = (r_op == FOP_SUB) ? r_b : {~r_b.sign, r_b.exposant, r_b.mantisse};
    assign w_sat = (w_y.exposant == EXP_SAT) && (&w_y.mantisse);
    assign w_unf = (w_y.exposant == '0) && (r_a.exposant != '0) && (r_b.exposant != '0)
                   && ((r_op == FOP_MUL) || (r_a != w_nb));
    assign w_set = {w_overrun, w_illegal, w_capture & w_unf, w_capture & w_sat};

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_cnt    <= '0;
            r_op     <= FOP_ADD;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_status <= '0;
            r_count  <= '0;
            r_ill    <= 1'b0;
        end else begin
            if (w_accept && !w_illegal) begin
                r_op  <= bus.opcode;
                r_a   <= bus.op_a;
                r_b   <= bus.op_b;
                r_cnt <= (bus.opcode == FOP_MUL) ? MUL_CNT : ADD_CNT;
            end else if (r_state == S_EXEC && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_illegal)      r_result <= '0;
            else if (w_capture) r_result <= w_y;
            if (w_accept) r_ill <= w_illegal;
            if (r_state == S_DONE && !r_ill) r_count <= r_count + 16'd1;
            r_status <= bus.clr_status ? w_set : (r_status | w_set);
        end
    end

    assign bus.busy     = (r_state != S_IDLE);
    assign bus.complete = (r_state == S_DONE);
    assign bus.result   = float'(r_result);
    assign bus.status   = r_status;
    assign bus.op_count = r_count;
endmodule

// File: tb/tb_float_copro_seq.sv
// Vector table plus hand sequences for reset, clear, illegal, overrun, back-to-back and abort.
module tb_float_copro_seq;
    import float_copro_seq_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    float_copro_seq_if bus();
    float_copro_seq dut (.i_clk(clk), .i_reset_n(reset_n), .bus(bus));

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  st;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  st;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic issue(logic [1:0] op, logic [31:0] a, logic [31:0] b,
                         logic [31:0] res, logic [3:0] st);
        exp_t e;
        bus.start      = 1'b1;
        bus.opcode     = fop_e'(op);
        bus.op_a       = a;
        bus.op_b       = b;
        bus.clr_status = 1'b1;
        e.res = res;
        e.st  = st;
        sb.push_back(e);
    endtask

    task automatic wait_done(string name, int lat);
        int   n;
        exp_t e;
        @(negedge clk);
        bus.start      = 1'b0;
        bus.clr_status = 1'b0;
        n = 1;
        while (!bus.complete && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("%s complete", name), {31'd0, bus.complete}, 32'd1);
        chk($sformatf("%s latency", name), n, lat);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("%s result", name), bus.result, e.res);
            chk($sformatf("%s status", name), {28'd0, bus.status}, {28'd0, e.st});
        end else begin
            chk($sformatf("%s scoreboard", name), 32'd0, 32'd1);
        end
    endtask

    vec_t tv[12];
    logic seen;

    initial begin
        tv[0]  = '{2'd0, 32'h3FC00000, 32'h40100000, 32'h40700000, 4'b0000, 3};
        tv[1]  = '{2'd2, 32'h40400000, 32'hC0000000, 32'hC0C00000, 4'b0000, 4};
        tv[2]  = '{2'd2, 32'h7F000000, 32'h7F000000, 32'h7F7FFFFF, 4'b0001, 4};
        tv[3]  = '{2'd1, 32'h40400000, 32'h3F800000, 32'h40000000, 4'b0000, 3};
        tv[4]  = '{2'd0, 32'h3F800000, 32'hBF800000, 32'h00000000, 4'b0000, 3};
        tv[5]  = '{2'd2, 32'h00800000, 32'h00800000, 32'h00000000, 4'b0010, 4};
        tv[6]  = '{2'd0, 32'h3F800000, 32'h3F800000, 32'h40000000, 4'b0000, 3};
        tv[7]  = '{2'd2, 32'h3F800000, 32'h00000000, 32'h00000000, 4'b0000, 4};
        tv[8]  = '{2'd0, 32'h40400000, 32'h00000000, 32'h40400000, 4'b0000, 3};
        tv[9]  = '{2'd1, 32'h00C00000, 32'h00800000, 32'h00000000, 4'b0010, 3};
        tv[10] = '{2'd0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF, 4'b0001, 3};
        tv[11] = '{2'd2, 32'h40000000, 32'h40000000, 32'h40800000, 4'b0000, 4};

        bus.start      = 1'b0;
        bus.opcode     = FOP_ADD;
        bus.op_a       = '0;
        bus.op_b       = '0;
        bus.clr_status = 1'b0;
        reset_n        = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset busy",     {31'd0, bus.busy}, 32'd0);
        chk("reset complete", {31'd0, bus.complete}, 32'd0);
        chk("reset result",   bus.result, 32'd0);
        chk("reset status",   {28'd0, bus.status}, 32'd0);
        chk("reset op_count", {16'd0, bus.op_count}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Table ops issue in the DONE cycle of the previous one (back-to-back).
        for (int i = 0; i < 12; i++) begin
            issue(tv[i].op, tv[i].a, tv[i].b, tv[i].res, tv[i].st);
            wait_done($sformatf("vec%0d", i), tv[i].lat);
            exp_cnt++;
            if (i == 0) begin
                @(negedge clk);
                chk("first op_count", {16'd0, bus.op_count}, exp_cnt);
            end
        end
        @(negedge clk);
        chk("table op_count", {16'd0, bus.op_count}, exp_cnt);

        issue(2'd2, 32'h7F000000, 32'h7F000000, 32'h7F7FFFFF, 4'b0001);
        wait_done("sat", 4);
        exp_cnt++;
        bus.clr_status = 1'b1;
        @(negedge clk);
        bus.clr_status = 1'b0;
        chk("sat clear", {28'd0, bus.status}, 32'd0);

        issue(2'd3, 32'h3F800000, 32'h3F800000, 32'h00000000, 4'b0100);
        wait_done("illegal", 1);
        @(negedge clk);
        chk("illegal op_count", {16'd0, bus.op_count}, exp_cnt);

        issue(2'd2, 32'h40000000, 32'h40000000, 32'h40800000, 4'b1000);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.opcode     = FOP_ADD;
        bus.op_a       = 32'h3F800000;
        bus.op_b       = 32'h3F800000;
        bus.clr_status = 1'b0;
        wait_done("overrun", 3);
        exp_cnt++;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.complete) seen = 1'b1;
        end
        chk("overrun extra complete", {31'd0, seen}, 32'd0);

        issue(2'd0, 32'h3F800000, 32'h3F800000, 32'h40000000, 4'b0000);
        wait_done("b2b first", 3);
        issue(2'd2, 32'h40400000, 32'hC0000000, 32'hC0C00000, 4'b0000);
        wait_done("b2b second", 4);
        exp_cnt += 2;
        @(negedge clk);
        chk("b2b op_count", {16'd0, bus.op_count}, exp_cnt);

        // Abort an op mid-EXEC with reset.
        reset_n = 1'b0;
        @(negedge clk);
        reset_n        = 1'b1;
        bus.start      = 1'b1;
        bus.opcode     = FOP_MUL;
        bus.op_a       = 32'h40400000;
        bus.op_b       = 32'h40400000;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("abort busy before", {31'd0, bus.busy}, 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.complete) seen = 1'b1;
        end
        chk("abort complete",  {31'd0, seen}, 32'd0);
        chk("abort result",    bus.result, 32'd0);
        chk("abort op_count",  {16'd0, bus.op_count}, 32'd0);
        chk("abort busy",      {31'd0, bus.busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
